// File: rtl/aes_axi_pkg.sv
// aes_axi_pkg: register map, bit positions, response codes and FSM encodings for aes_axi_regif.
package aes_axi_pkg;
  localparam logic [3:0] IDX_CTRL = 4'h0;
  localparam logic [3:0] IDX_STATUS = 4'h1;
  localparam logic [1:0] GRP_CSR = 2'd0;
  localparam logic [1:0] GRP_KEY = 2'd1;
  localparam logic [1:0] GRP_TIN = 2'd2;
  localparam logic [1:0] GRP_TOUT = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_DEC = 1;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [2:0] SIZE_WORD = 3'b010;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  function automatic logic [3:0] next_idx(input logic [3:0] idx, input logic [1:0] burst);
    return burst == BURST_FIXED ? idx : idx + 4'd1;
  endfunction
  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
    return m;
  endfunction
endpackage

// File: rtl/aes_regfile.sv
// aes_regfile: AES control/status, key, text-in and text-out registers plus the start/done handshake.
module aes_regfile
  import aes_axi_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [3:0]   wr_idx,
  input  logic [31:0]  wr_data,
  input  logic [3:0]   wr_strb,
  output logic         wr_err,
  input  logic [3:0]   rd_idx,
  output logic [31:0]  rd_data,
  output logic [127:0] aes_key,
  output logic [127:0] aes_din,
  output logic         aes_dec,
  output logic         aes_start,
  input  logic [127:0] aes_dout,
  input  logic         aes_done
);
  logic [127:0] tout;
  logic busy, done, start_wr, wr_ok, start_req, w1c_done;
  logic [6:0] wr_lsb, rd_lsb;
  assign wr_lsb = {wr_idx[1:0], 5'd0};
  assign rd_lsb = {rd_idx[1:0], 5'd0};
  assign start_wr = wr_idx == IDX_CTRL && wr_strb[0] && wr_data[CTRL_START];
  // A start while busy, a write of BUSY=1 and any TOUT write reject the whole beat.
  assign wr_err = (wr_idx == IDX_STATUS && wr_strb[0] && wr_data[ST_BUSY]) || wr_idx[3:2] == GRP_TOUT || (start_wr && busy);
  assign wr_ok = wr_en && !wr_err;
  assign start_req = wr_ok && start_wr;
  assign w1c_done = wr_ok && wr_idx == IDX_STATUS && wr_strb[0] && wr_data[ST_DONE];
  always_comb begin
    rd_data = '0;
    case (rd_idx[3:2])
      GRP_CSR: rd_data = rd_idx == IDX_CTRL ? {30'd0, aes_dec, 1'b0} : rd_idx == IDX_STATUS ? {30'd0, done, busy} : '0;
      GRP_KEY: rd_data = aes_key[rd_lsb +: 32];
      GRP_TIN: rd_data = aes_din[rd_lsb +: 32];
      default: rd_data = tout[rd_lsb +: 32];
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aes_key <= '0;
      aes_din <= '0;
      tout <= '0;
      aes_dec <= 1'b0;
      aes_start <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      aes_start <= start_req;
      if (wr_ok && wr_idx[3:2] == GRP_KEY) aes_key[wr_lsb +: 32] <= merge_bytes(aes_key[wr_lsb +: 32], wr_data, wr_strb);
      if (wr_ok && wr_idx[3:2] == GRP_TIN) aes_din[wr_lsb +: 32] <= merge_bytes(aes_din[wr_lsb +: 32], wr_data, wr_strb);
      if (wr_ok && wr_idx == IDX_CTRL && wr_strb[0]) aes_dec <= wr_data[CTRL_DEC];
      // Capture of a result outranks a same-cycle W1C of DONE; start and capture are exclusive via busy.
      if (aes_done && busy) begin
        tout <= aes_dout;
        busy <= 1'b0;
        done <= 1'b1;
      end else if (start_req) begin
        busy <= 1'b1;
        done <= 1'b0;
      end else if (w1c_done) begin
        done <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/aes_axi_regif.sv
// aes_axi_regif: AXI3 slave exposing the AES core registers with independent read and write burst FSMs.
module aes_axi_regif
  import aes_axi_pkg::*;
#(
  parameter int AXI_WIDTH_CID = 4,
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int AXI_WIDTH_DS = AXI_WIDTH_DA / 8,
  parameter int AXI_WIDTH_SID = AXI_WIDTH_CID + AXI_WIDTH_ID
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [AXI_WIDTH_SID-1:0] AWID,
  input  logic [AXI_WIDTH_AD-1:0]  AWADDR,
  input  logic [3:0]               AWLEN,
  input  logic [1:0]               AWLOCK,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [AXI_WIDTH_SID-1:0] WID,
  input  logic [AXI_WIDTH_DA-1:0]  WDATA,
  input  logic [AXI_WIDTH_DS-1:0]  WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [AXI_WIDTH_SID-1:0] BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [AXI_WIDTH_SID-1:0] ARID,
  input  logic [AXI_WIDTH_AD-1:0]  ARADDR,
  input  logic [3:0]               ARLEN,
  input  logic [1:0]               ARLOCK,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [AXI_WIDTH_SID-1:0] RID,
  output logic [AXI_WIDTH_DA-1:0]  RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [127:0]             aes_key,
  output logic [127:0]             aes_din,
  output logic                     aes_dec,
  output logic                     aes_start,
  input  logic [127:0]             aes_dout,
  input  logic                     aes_done
);
  w_state_e w_state, w_next;
  r_state_e r_state, r_next;
  logic run, w_size_err, w_err, w_beat, w_beat_err, rf_wr_err;
  logic r_size_err, aw_hs, ar_hs, r_beat;
  logic [3:0] w_idx, r_idx, rd_idx, r_cnt;
  logic [1:0] w_burst, r_burst;
  logic [31:0] rd_data;
  logic unused;
  assign unused = ^{AWADDR[AXI_WIDTH_AD-1:6], AWADDR[1:0], ARADDR[AXI_WIDTH_AD-1:6], ARADDR[1:0], AWLEN, AWLOCK, ARLOCK, WID};
  // run holds the address channels closed for the first cycle out of reset.
  assign AWREADY = run && w_state == W_IDLE;
  assign WREADY = w_state == W_DATA;
  assign BVALID = w_state == W_RESP;
  assign ARREADY = run && r_state == R_IDLE;
  assign RVALID = r_state == R_DATA;
  assign aw_hs = AWVALID && AWREADY;
  assign w_beat = WVALID && WREADY;
  assign w_beat_err = w_size_err || rf_wr_err;
  assign ar_hs = ARVALID && ARREADY;
  assign r_beat = RVALID && RREADY;
  assign rd_idx = r_state == R_IDLE ? ARADDR[5:2] : next_idx(r_idx, r_burst);
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: w_next = aw_hs ? W_DATA : W_IDLE;
      W_DATA: w_next = w_beat && WLAST ? W_RESP : W_DATA;
      W_RESP: w_next = BREADY ? W_IDLE : W_RESP;
      default: w_next = W_IDLE;
    endcase
  end
  always_comb begin
    r_next = r_state;
    r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (r_beat && RLAST ? R_IDLE : R_DATA);
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      run <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      run <= 1'b1;
      w_state <= w_next;
      r_state <= r_next;
    end
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_idx <= '0;
      w_burst <= '0;
      w_size_err <= 1'b0;
      w_err <= 1'b0;
      BID <= '0;
      BRESP <= RESP_OKAY;
    end else if (aw_hs) begin
      w_idx <= AWADDR[5:2];
      w_burst <= AWBURST;
      w_size_err <= AWSIZE != SIZE_WORD;
      w_err <= 1'b0;
      BID <= AWID;
    end else if (w_beat) begin
      w_idx <= next_idx(w_idx, w_burst);
      w_err <= w_err || w_beat_err;
      if (WLAST) BRESP <= w_err || w_beat_err ? RESP_SLVERR : RESP_OKAY;
    end
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_idx <= '0;
      r_burst <= '0;
      r_cnt <= '0;
      r_size_err <= 1'b0;
      RID <= '0;
      RDATA <= '0;
      RRESP <= RESP_OKAY;
      RLAST <= 1'b0;
    end else if (ar_hs) begin
      r_idx <= rd_idx;
      r_burst <= ARBURST;
      r_cnt <= ARLEN;
      r_size_err <= ARSIZE != SIZE_WORD;
      RID <= ARID;
      RDATA <= ARSIZE != SIZE_WORD ? '0 : rd_data;
      RRESP <= ARSIZE != SIZE_WORD ? RESP_SLVERR : RESP_OKAY;
      RLAST <= ARLEN == 4'd0;
    end else if (r_beat && !RLAST) begin
      r_idx <= rd_idx;
      r_cnt <= r_cnt - 4'd1;
      RDATA <= r_size_err ? '0 : rd_data;
      RLAST <= r_cnt == 4'd1;
    end else if (r_beat) begin
      RLAST <= 1'b0;
    end
  end
  aes_regfile u_regfile (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .wr_en     (w_beat && !w_size_err),
    .wr_idx    (w_idx),
    .wr_data   (WDATA),
    .wr_strb   (WSTRB),
    .wr_err    (rf_wr_err),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .aes_key   (aes_key),
    .aes_din   (aes_din),
    .aes_dec   (aes_dec),
    .aes_start (aes_start),
    .aes_dout  (aes_dout),
    .aes_done  (aes_done)
  );
endmodule

// File: tb/tb_aes_axi_regif.sv
// tb_aes_axi_regif: directed bench for aes_axi_regif with a delayed-result AES core model.
module tb_aes_axi_regif;
  localparam logic [127:0] CORE_OUT = 128'h70b4c55a_d8cdb780_6a7b0430_69c4e0d8;
  logic ACLK = 1'b0, ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;
  logic [7:0] AWID = '0, WID = '0, ARID = '0, BID, RID;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA;
  logic [3:0] AWLEN = '0, ARLEN = '0, WSTRB = '0;
  logic [1:0] AWLOCK = '0, ARLOCK = '0, AWBURST = '0, ARBURST = '0, BRESP, RRESP;
  logic [2:0] AWSIZE = '0, ARSIZE = '0;
  logic AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
  logic [127:0] aes_key, aes_din, aes_dout = CORE_OUT;
  logic aes_dec, aes_start, aes_done = 1'b0, kick = 1'b0;
  int checks = 0, errors = 0;
  int core_delay = 3, core_cnt = 0, start_pulses = 0, done_pulses = 0;
  logic [31:0] wbuf [4];
  logic [31:0] rbuf [4];
  logic [3:0] wstrb = 4'hF, rlast_v;
  logic [1:0] bresp_o, rresp_o;
  logic [7:0] bid_o, rid_o;
  logic [31:0] rd;
  int abort_beat = -1, nbeats, stable_err;

  aes_axi_regif dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWLOCK(AWLOCK), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARLOCK(ARLOCK), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .aes_key(aes_key), .aes_din(aes_din), .aes_dec(aes_dec), .aes_start(aes_start),
    .aes_dout(aes_dout), .aes_done(aes_done)
  );

  // Core model: result pulse core_delay cycles after start; kick forces a stray pulse.
  always @(posedge ACLK) begin
    if (aes_start) start_pulses++;
    if (aes_done) done_pulses++;
    if (aes_start) core_cnt <= core_delay;
    else if (core_cnt > 0) core_cnt <= core_cnt - 1;
    aes_done <= core_cnt == 1 || kick;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic axi_write(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] burst, input logic [3:0] len, input logic [7:0] id);
    int t;
    bresp_o = 2'bxx;
    bid_o = 8'hxx;
    AWADDR = addr; AWSIZE = size; AWBURST = burst; AWLEN = len; AWID = id; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 100) begin @(posedge ACLK); #1; t++; end
    if (t >= 100) begin checks++; errors++; $display("FAIL aw_timeout got AWREADY=%b exp 1", AWREADY); end
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wbuf[i]; WSTRB = wstrb; WLAST = i == int'(len); WID = id; WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 100) begin @(posedge ACLK); #1; t++; end
      if (t >= 100) begin checks++; errors++; $display("FAIL w_timeout got WREADY=%b exp 1", WREADY); end
      @(posedge ACLK); #1;
      WVALID = 1'b0; WLAST = 1'b0;
      if (i == abort_beat) return;
    end
    BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 100) begin @(posedge ACLK); #1; t++; end
    if (t >= 100) begin checks++; errors++; $display("FAIL b_timeout got BVALID=%b exp 1", BVALID); end
    bresp_o = BRESP;
    bid_o = BID;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] burst, input logic [3:0] len, input logic [7:0] id, input bit toggle);
    int t;
    logic [31:0] pd;
    logic pl;
    bit stall;
    for (int i = 0; i < 4; i++) rbuf[i] = 'x;
    ARADDR = addr; ARSIZE = size; ARBURST = burst; ARLEN = len; ARID = id; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 100) begin @(posedge ACLK); #1; t++; end
    if (t >= 100) begin checks++; errors++; $display("FAIL ar_timeout got ARREADY=%b exp 1", ARREADY); end
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    nbeats = 0; stable_err = 0; rlast_v = '0; rresp_o = '0; rid_o = 'x; t = 0;
    while (nbeats <= int'(len) && t < 200) begin
      RREADY = toggle ? !t[0] : 1'b1;
      if (RVALID && RREADY) begin
        rbuf[nbeats] = RDATA; rlast_v[nbeats] = RLAST; rresp_o |= RRESP; rid_o = RID; nbeats++;
      end
      stall = RVALID && !RREADY; pd = RDATA; pl = RLAST;
      @(posedge ACLK); #1;
      t++;
      if (stall && (!RVALID || RDATA !== pd || RLAST !== pl)) stable_err++;
    end
    RREADY = 1'b0;
    if (t >= 200) begin checks++; errors++; $display("FAIL r_timeout got beats=%0d exp %0d", nbeats, int'(len) + 1); end
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] d);
    axi_read(addr, 3'b010, 2'b01, 4'd0, 8'h11, 1'b0);
    d = rbuf[0];
  endtask

  task automatic test_reset;
    repeat (3) @(posedge ACLK);
    #1;
    checks++;
    if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, aes_start} !== 7'd0 || aes_key !== '0) begin
      errors++; $display("FAIL reset_outputs got %b key %h exp 0", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, aes_start}, aes_key);
    end
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if ({AWREADY, ARREADY} !== 2'b11) begin errors++; $display("FAIL ready_after_reset got %b exp 11", {AWREADY, ARREADY}); end
    read_reg(32'h04, rd);
    checks++;
    if (rd !== 32'h0 || rresp_o !== 2'b00) begin errors++; $display("FAIL reset_status got %h/%b exp 0/00", rd, rresp_o); end
  endtask

  task automatic test_key_burst;
    wbuf = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    wstrb = 4'hF;
    axi_write(32'h10, 3'b010, 2'b01, 4'd3, 8'h5A);
    checks++;
    if (bresp_o !== 2'b00 || bid_o !== 8'h5A) begin errors++; $display("FAIL key_bresp got %b/%h exp 00/5a", bresp_o, bid_o); end
    checks++;
    if (aes_key !== 128'h0c0d0e0f_08090a0b_04050607_00010203) begin errors++; $display("FAIL key_vector got %h exp 0c0d0e0f08090a0b0405060700010203", aes_key); end
    read_reg(32'h18, rd);
    checks++;
    if (rd !== 32'h08090a0b) begin errors++; $display("FAIL key2_read got %h exp 08090a0b", rd); end
  endtask

  task automatic test_strobe;
    wbuf[0] = 32'hAABBCCDD; wstrb = 4'hF;
    axi_write(32'h20, 3'b010, 2'b01, 4'd0, 8'h01);
    wbuf[0] = 32'h11223344; wstrb = 4'b0101;
    axi_write(32'h1000_0020, 3'b010, 2'b01, 4'd0, 8'h02);
    wstrb = 4'hF;
    checks++;
    if (aes_din[31:0] !== 32'hAA22CC44) begin errors++; $display("FAIL strobe_din got %h exp aa22cc44", aes_din[31:0]); end
    read_reg(32'h20, rd);
    checks++;
    if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL strobe_read got %h exp aa22cc44", rd); end
  endtask

  task automatic test_start_done;
    int p0, d0, t;
    core_delay = 20;
    p0 = start_pulses; d0 = done_pulses;
    wbuf[0] = 32'h1;
    axi_write(32'h00, 3'b010, 2'b01, 4'd0, 8'h21);
    checks++;
    if (bresp_o !== 2'b00) begin errors++; $display("FAIL start_bresp got %b exp 00", bresp_o); end
    read_reg(32'h04, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL status_busy got %h exp 1", rd); end
    axi_write(32'h00, 3'b010, 2'b01, 4'd0, 8'h22);
    checks++;
    if (bresp_o !== 2'b10) begin errors++; $display("FAIL start_busy_bresp got %b exp 10", bresp_o); end
    t = 0;
    while (done_pulses == d0 && t < 200) begin @(posedge ACLK); #1; t++; end
    if (t >= 200) begin checks++; errors++; $display("FAIL done_timeout got done_pulses=%0d exp >%0d", done_pulses, d0); end
    checks++;
    if (start_pulses - p0 !== 1) begin errors++; $display("FAIL start_pulses got %0d exp 1", start_pulses - p0); end
    read_reg(32'h04, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL status_done got %h exp 2", rd); end
    read_reg(32'h30, rd);
    checks++;
    if (rd !== 32'h69c4e0d8) begin errors++; $display("FAIL tout0 got %h exp 69c4e0d8", rd); end
    read_reg(32'h3C, rd);
    checks++;
    if (rd !== 32'h70b4c55a) begin errors++; $display("FAIL tout3 got %h exp 70b4c55a", rd); end
    aes_dout = '1; kick = 1'b1;
    @(posedge ACLK); #1;
    kick = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    aes_dout = CORE_OUT;
    read_reg(32'h30, rd);
    checks++;
    if (rd !== 32'h69c4e0d8) begin errors++; $display("FAIL idle_done_ignored got %h exp 69c4e0d8", rd); end
    wbuf[0] = 32'h2;
    axi_write(32'h04, 3'b010, 2'b01, 4'd0, 8'h23);
    read_reg(32'h04, rd);
    checks++;
    if (rd !== 32'h0 || bresp_o !== 2'b00) begin errors++; $display("FAIL done_w1c got %h/%b exp 0/00", rd, bresp_o); end
    axi_write(32'h00, 3'b010, 2'b01, 4'd0, 8'h24);
    read_reg(32'h00, rd);
    checks++;
    if (aes_dec !== 1'b1 || rd !== 32'h2 || start_pulses - p0 !== 1) begin
      errors++; $display("FAIL ctrl_dec got dec=%b rd=%h pulses=%0d exp 1/2/1", aes_dec, rd, start_pulses - p0);
    end
  endtask

  task automatic test_errors;
    wbuf[0] = 32'hDEADBEEF;
    axi_write(32'h20, 3'b001, 2'b01, 4'd0, 8'h31);
    checks++;
    if (bresp_o !== 2'b10 || aes_din[31:0] !== 32'hAA22CC44) begin errors++; $display("FAIL size_err got %b/%h exp 10/aa22cc44", bresp_o, aes_din[31:0]); end
    axi_write(32'h30, 3'b010, 2'b01, 4'd0, 8'h32);
    checks++;
    if (bresp_o !== 2'b10) begin errors++; $display("FAIL tout_write got %b exp 10", bresp_o); end
    wbuf[0] = 32'h1;
    axi_write(32'h04, 3'b010, 2'b01, 4'd0, 8'h33);
    checks++;
    if (bresp_o !== 2'b10) begin errors++; $display("FAIL busy_write got %b exp 10", bresp_o); end
    wbuf[0] = 32'h12345678;
    axi_write(32'h08, 3'b010, 2'b01, 4'd0, 8'h34);
    read_reg(32'h08, rd);
    checks++;
    if (bresp_o !== 2'b00 || rd !== 32'h0 || rresp_o !== 2'b00) begin errors++; $display("FAIL unmapped got %b/%h/%b exp 00/0/00", bresp_o, rd, rresp_o); end
    wbuf[0] = 32'hCAFEF00D; wbuf[1] = 32'h11111111;
    axi_write(32'h2C, 3'b010, 2'b01, 4'd1, 8'h35);
    checks++;
    if (bresp_o !== 2'b10 || aes_din[127:96] !== 32'hCAFEF00D) begin errors++; $display("FAIL mixed_burst got %b/%h exp 10/cafef00d", bresp_o, aes_din[127:96]); end
    axi_read(32'h3C, 3'b010, 2'b10, 4'd1, 8'h36, 1'b0);
    checks++;
    if (rbuf[0] !== 32'h70b4c55a || rbuf[1] !== 32'h2 || rlast_v !== 4'b0010) begin
      errors++; $display("FAIL wrap_read got %h %h last=%b exp 70b4c55a 2 0010", rbuf[0], rbuf[1], rlast_v);
    end
    axi_read(32'h20, 3'b001, 2'b01, 4'd0, 8'h37, 1'b0);
    checks++;
    if (rresp_o !== 2'b10) begin errors++; $display("FAIL read_size_err got %b exp 10", rresp_o); end
  endtask

  task automatic test_fixed_read;
    core_delay = 60;
    wbuf[0] = 32'h3;
    axi_write(32'h00, 3'b010, 2'b01, 4'd0, 8'h41);
    axi_read(32'h04, 3'b010, 2'b00, 4'd3, 8'hA5, 1'b1);
    checks++;
    if (nbeats !== 4 || rlast_v !== 4'b1000) begin errors++; $display("FAIL fixed_rlast got beats=%0d last=%b exp 4/1000", nbeats, rlast_v); end
    checks++;
    if (rbuf[0] !== 32'h1 || rbuf[1] !== 32'h1 || rbuf[2] !== 32'h1 || rbuf[3] !== 32'h1) begin
      errors++; $display("FAIL fixed_data got %h %h %h %h exp 1 1 1 1", rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
    end
    checks++;
    if (rid_o !== 8'hA5 || rresp_o !== 2'b00) begin errors++; $display("FAIL fixed_rid got %h/%b exp a5/00", rid_o, rresp_o); end
    checks++;
    if (stable_err !== 0 || RVALID !== 1'b0) begin errors++; $display("FAIL stall_stable got %0d unstable, RVALID=%b exp 0/0", stable_err, RVALID); end
  endtask

  task automatic test_reset_midburst;
    wbuf = '{32'h1, 32'h2, 32'h3, 32'h4};
    abort_beat = 1;
    axi_write(32'h20, 3'b010, 2'b01, 4'd3, 8'h51);
    abort_beat = -1;
    checks++;
    if (aes_din[63:0] !== 64'h00000002_00000001 || WREADY !== 1'b1) begin errors++; $display("FAIL partial_burst got %h/%b exp 0000000200000001/1", aes_din[63:0], WREADY); end
    ARESETn = 1'b0;
    #1;
    checks++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, aes_start} !== 7'd0 || aes_din !== '0 || BRESP !== 2'b00) begin
      errors++; $display("FAIL async_reset got %b din=%h bresp=%b exp 0", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, aes_start}, aes_din, BRESP);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    wbuf[0] = 32'h55AA55AA;
    axi_write(32'h10, 3'b010, 2'b01, 4'd0, 8'h52);
    checks++;
    if (bresp_o !== 2'b00 || bid_o !== 8'h52 || aes_key[31:0] !== 32'h55AA55AA) begin
      errors++; $display("FAIL post_reset_write got %b/%h/%h exp 00/52/55aa55aa", bresp_o, bid_o, aes_key[31:0]);
    end
  endtask

  initial begin
    test_reset;
    test_key_burst;
    test_strobe;
    test_start_done;
    test_errors;
    test_fixed_read;
    test_reset_midburst;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
